// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer arithmetic.
// The read-side and write-side controllers both import this package.
package fifo_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

    // Fill level between two wrap-bit pointers of arbitrary width, modulo 2**width.
    // Callers keep only the low PTR_WIDTH bits of the result.
    function automatic logic [31:0] ptr_diff(
        input logic [31:0] wr_ptr,
        input logic [31:0] rd_ptr,
        input int          width
    );
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus: write pointer in, read pointer, memory strobe and status out.
// The master modport is the consumer/write-side view; the slave modport is the controller.
interface fifo_rd_ctrl_if #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
);
    logic [ADDR_WIDTH:0]   i_wr_address;
    logic                  i_rd_en;
    logic [ADDR_WIDTH:0]   o_rd_address;
    logic                  o_mem_rd_en;
    logic [ADDR_WIDTH-1:0] o_mem_rd_addr;
    logic                  o_rd_valid;
    logic                  o_Empty_Flag;
    logic                  o_almost_empty;
    logic [ADDR_WIDTH:0]   o_fill_level;
    logic                  o_underflow;
    logic                  o_ptr_err;

    modport master (
        output i_wr_address, i_rd_en,
        input  o_rd_address, o_mem_rd_en, o_mem_rd_addr, o_rd_valid,
        input  o_Empty_Flag, o_almost_empty, o_fill_level, o_underflow, o_ptr_err
    );

    modport slave (
        input  i_wr_address, i_rd_en,
        output o_rd_address, o_mem_rd_en, o_mem_rd_addr, o_rd_valid,
        output o_Empty_Flag, o_almost_empty, o_fill_level, o_underflow, o_ptr_err
    );
endinterface

// File: rtl/fifo_rd_ctrl_empty_flag_gen.sv
// Empty flag: full-width pointer compare, wrap bit included.
// Mirror image of the write side's full-flag generator.
module Empty_Flag_Gen #(
    parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH
) (
    input  logic [PTR_WIDTH-1:0] i_wr_ptr,
    input  logic [PTR_WIDTH-1:0] i_rd_ptr,
    output logic                 o_empty
);
    assign o_empty = (i_wr_ptr == i_rd_ptr);
endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: owns the read pointer, issues memory reads,
// aligns read-valid with one-cycle memory latency and reports fill status.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int AE_THRESH  = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fifo_rd_ctrl_if.slave bus
);
    localparam int                   P_WIDTH = ADDR_WIDTH + 1;
    localparam int                   P_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [P_WIDTH-1:0]   AE_LVL  = P_WIDTH'(AE_THRESH);
    localparam logic [P_WIDTH:0]     DEPTH_X = (P_WIDTH+1)'(P_DEPTH);

    logic [P_WIDTH-1:0] r_rd_ptr;
    logic               r_rd_valid;
    logic               r_underflow;
    logic               r_ptr_err;

    logic               w_empty;
    logic               w_rd_accept;
    logic [31:0]        w_diff;
    logic [P_WIDTH-1:0] w_fill;

    Empty_Flag_Gen #(.PTR_WIDTH(P_WIDTH)) u_empty (
        .i_wr_ptr (bus.i_wr_address),
        .i_rd_ptr (r_rd_ptr),
        .o_empty  (w_empty)
    );

    assign w_diff      = ptr_diff(32'(bus.i_wr_address), 32'(r_rd_ptr), P_WIDTH);
    assign w_fill      = w_diff[P_WIDTH-1:0];
    assign w_rd_accept = bus.i_rd_en & ~w_empty;

    // A write landing in the same cycle as a read on empty is not bypassed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr    <= '0;
            r_rd_valid  <= 1'b0;
            r_underflow <= 1'b0;
            r_ptr_err   <= 1'b0;
        end else begin
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_valid  <= w_rd_accept;
            r_underflow <= bus.i_rd_en & w_empty;
            if ({1'b0, w_fill} > DEPTH_X) begin
                r_ptr_err <= 1'b1;
            end
        end
    end

    assign bus.o_rd_address   = r_rd_ptr;
    assign bus.o_mem_rd_en    = w_rd_accept;
    assign bus.o_mem_rd_addr  = r_rd_ptr[ADDR_WIDTH-1:0];
    assign bus.o_rd_valid     = r_rd_valid;
    assign bus.o_Empty_Flag   = w_empty;
    assign bus.o_almost_empty = (w_fill <= AE_LVL);
    assign bus.o_fill_level   = w_fill;
    assign bus.o_underflow    = r_underflow;
    assign bus.o_ptr_err      = r_ptr_err;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with ADDR_WIDTH=5, AE_THRESH=2.
module tb_fifo_rd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.ADDR_WIDTH(5)) bus ();

    fifo_rd_ctrl #(.ADDR_WIDTH(5), .AE_THRESH(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.i_wr_address = 6'd0;
        bus.i_rd_en      = 1'b0;

        // Reset
        step(); step();
        $display("reset: empty=%0d fill=%0d", bus.o_Empty_Flag, bus.o_fill_level);
        chk("rst_empty", 32'(bus.o_Empty_Flag), 1);
        chk("rst_fill", 32'(bus.o_fill_level), 0);
        chk("rst_ae", 32'(bus.o_almost_empty), 1);
        chk("rst_valid", 32'(bus.o_rd_valid), 0);
        chk("rst_rdaddr", 32'(bus.o_rd_address), 0);
        chk("rst_perr", 32'(bus.o_ptr_err), 0);
        chk("rst_uflow", 32'(bus.o_underflow), 0);
        rst = 1'b0;

        // Basic read of three entries
        bus.i_wr_address = 6'd3;
        bus.i_rd_en      = 1'b1;
        settle();
        $display("read0: addr=%0d fill=%0d", bus.o_mem_rd_addr, bus.o_fill_level);
        chk("rd0_fill", 32'(bus.o_fill_level), 3);
        chk("rd0_en", 32'(bus.o_mem_rd_en), 1);
        chk("rd0_addr", 32'(bus.o_mem_rd_addr), 0);
        chk("rd0_ae", 32'(bus.o_almost_empty), 0);
        chk("rd0_valid", 32'(bus.o_rd_valid), 0);
        step();
        $display("read1: addr=%0d fill=%0d valid=%0d", bus.o_mem_rd_addr, bus.o_fill_level, bus.o_rd_valid);
        chk("rd1_addr", 32'(bus.o_mem_rd_addr), 1);
        chk("rd1_fill", 32'(bus.o_fill_level), 2);
        chk("rd1_valid", 32'(bus.o_rd_valid), 1);
        chk("rd1_ae", 32'(bus.o_almost_empty), 1);
        step();
        $display("read2: addr=%0d fill=%0d valid=%0d", bus.o_mem_rd_addr, bus.o_fill_level, bus.o_rd_valid);
        chk("rd2_addr", 32'(bus.o_mem_rd_addr), 2);
        chk("rd2_fill", 32'(bus.o_fill_level), 1);
        chk("rd2_valid", 32'(bus.o_rd_valid), 1);
        step();
        bus.i_rd_en = 1'b0;
        settle();
        $display("read3: fill=%0d empty=%0d valid=%0d", bus.o_fill_level, bus.o_Empty_Flag, bus.o_rd_valid);
        chk("rd3_fill", 32'(bus.o_fill_level), 0);
        chk("rd3_empty", 32'(bus.o_Empty_Flag), 1);
        chk("rd3_valid", 32'(bus.o_rd_valid), 1);
        chk("rd3_ptr", 32'(bus.o_rd_address), 3);
        step();
        chk("rd4_valid", 32'(bus.o_rd_valid), 0);

        // Underflow on empty
        bus.i_rd_en = 1'b1;
        settle();
        chk("uf_memen", 32'(bus.o_mem_rd_en), 0);
        step();
        bus.i_rd_en = 1'b0;
        $display("underflow: uf=%0d ptr=%0d", bus.o_underflow, bus.o_rd_address);
        chk("uf_pulse", 32'(bus.o_underflow), 1);
        chk("uf_ptr", 32'(bus.o_rd_address), 3);
        chk("uf_valid", 32'(bus.o_rd_valid), 0);
        step();
        chk("uf_clear", 32'(bus.o_underflow), 0);

        // Advance pointer to 31
        bus.i_wr_address = 6'd31;
        bus.i_rd_en      = 1'b1;
        repeat (28) step();
        bus.i_rd_en = 1'b0;
        settle();
        chk("adv_ptr", 32'(bus.o_rd_address), 31);

        // Full level and wrap
        bus.i_wr_address = 6'b111111;
        settle();
        $display("full: fill=%0d addr=%0d", bus.o_fill_level, bus.o_mem_rd_addr);
        chk("full_fill", 32'(bus.o_fill_level), 32);
        chk("full_empty", 32'(bus.o_Empty_Flag), 0);
        chk("full_addr", 32'(bus.o_mem_rd_addr), 31);
        chk("full_ae", 32'(bus.o_almost_empty), 0);
        bus.i_rd_en = 1'b1;
        step();
        bus.i_rd_en = 1'b0;
        settle();
        $display("wrap: ptr=%0d addr=%0d fill=%0d", bus.o_rd_address, bus.o_mem_rd_addr, bus.o_fill_level);
        chk("wrap_ptr", 32'(bus.o_rd_address), 32);
        chk("wrap_addr", 32'(bus.o_mem_rd_addr), 0);
        chk("wrap_fill", 32'(bus.o_fill_level), 31);
        chk("wrap_perr", 32'(bus.o_ptr_err), 0);

        // Advance to pointer 36 and go empty
        bus.i_wr_address = 6'd36;
        bus.i_rd_en      = 1'b1;
        repeat (4) step();
        bus.i_rd_en = 1'b0;
        settle();
        chk("sim_empty0", 32'(bus.o_Empty_Flag), 1);

        // Read on empty while a write lands in the same cycle
        bus.i_rd_en = 1'b1;
        settle();
        chk("sim_memen0", 32'(bus.o_mem_rd_en), 0);
        step();
        bus.i_wr_address = 6'd37;
        settle();
        $display("simul: uf=%0d ptr=%0d fill=%0d", bus.o_underflow, bus.o_rd_address, bus.o_fill_level);
        chk("sim_uf", 32'(bus.o_underflow), 1);
        chk("sim_ptr", 32'(bus.o_rd_address), 36);
        chk("sim_fill", 32'(bus.o_fill_level), 1);
        chk("sim_memen1", 32'(bus.o_mem_rd_en), 1);
        step();
        bus.i_rd_en = 1'b0;
        settle();
        chk("sim_ptr2", 32'(bus.o_rd_address), 37);
        chk("sim_valid", 32'(bus.o_rd_valid), 1);
        chk("sim_uf2", 32'(bus.o_underflow), 0);
        chk("sim_empty2", 32'(bus.o_Empty_Flag), 1);

        // Concurrent write and read at fill 10
        bus.i_wr_address = 6'd47;
        bus.i_rd_en      = 1'b1;
        settle();
        chk("cc_fill0", 32'(bus.o_fill_level), 10);
        step();
        bus.i_wr_address = 6'd48;
        bus.i_rd_en      = 1'b0;
        settle();
        $display("concurrent: fill=%0d ptr=%0d", bus.o_fill_level, bus.o_rd_address);
        chk("cc_fill1", 32'(bus.o_fill_level), 10);
        chk("cc_ptr", 32'(bus.o_rd_address), 38);

        // Pointer corruption: fill 40
        bus.i_wr_address = 6'd14;
        settle();
        chk("pe_fill", 32'(bus.o_fill_level), 40);
        chk("pe_pre", 32'(bus.o_ptr_err), 0);
        step();
        chk("pe_set", 32'(bus.o_ptr_err), 1);
        bus.i_wr_address = 6'd48;
        step();
        $display("ptr_err: perr=%0d fill=%0d", bus.o_ptr_err, bus.o_fill_level);
        chk("pe_sticky", 32'(bus.o_ptr_err), 1);

        // Reset mid-burst
        bus.i_rd_en = 1'b1;
        step();
        chk("mr_valid", 32'(bus.o_rd_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_rd_en = 1'b0;
        bus.i_wr_address = 6'd0;
        settle();
        $display("midreset: valid=%0d ptr=%0d perr=%0d", bus.o_rd_valid, bus.o_rd_address, bus.o_ptr_err);
        chk("mr_valid0", 32'(bus.o_rd_valid), 0);
        chk("mr_ptr", 32'(bus.o_rd_address), 0);
        chk("mr_perr", 32'(bus.o_ptr_err), 0);
        chk("mr_empty", 32'(bus.o_Empty_Flag), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller of the synchronous FIFO, the counterpart of the write-side full-flag logic. It owns the read pointer and generates the empty, almost-empty and fill-level status. It issues read strobes and addresses to the synchronous-read FIFO memory and produces a read-valid aligned with memory data. It takes the write pointer (ADDR_WIDTH+1 bits, MSB = wrap bit) from the write side and exports its own read pointer back for full-flag generation.

Parameters:
ADDR_WIDTH, 5, memory address width; DEPTH = 2**ADDR_WIDTH entries; pointers are ADDR_WIDTH+1 bits
AE_THRESH, 2, o_almost_empty asserted when fill level <= AE_THRESH (legal range 0..DEPTH-1)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
i_wr_address  in  ADDR_WIDTH+1  write pointer from write side, wrap bit in MSB
i_rd_en  in  1  read request from consumer
o_rd_address  out  ADDR_WIDTH+1  current read pointer, exported to full-flag logic
o_mem_rd_en  out  1  memory read strobe (accepted read)
o_mem_rd_addr  out  ADDR_WIDTH  memory address = o_rd_address[ADDR_WIDTH-1:0]
o_rd_valid  out  1  memory read data valid this cycle
o_Empty_Flag  out  1  FIFO empty
o_almost_empty  out  1  fill level <= AE_THRESH
o_fill_level  out  ADDR_WIDTH+1  entries currently stored, 0..DEPTH
o_underflow  out  1  one-cycle pulse: read requested while empty
o_ptr_err  out  1  sticky: fill level exceeded DEPTH (pointer corruption)

Behaviour:
- Reset (i_rst=1 at edge): rd pointer=0, o_rd_valid=0, o_underflow=0, o_ptr_err=0. Combinational outputs follow from pointer=0 and i_wr_address. The write side is reset by the same i_rst, so after reset o_Empty_Flag=1 and o_fill_level=0.
- Empty: o_Empty_Flag = (i_wr_address == rd pointer), full ADDR_WIDTH+1-bit compare. Combinational; no clock delay.
- Fill: o_fill_level = (i_wr_address - rd pointer) modulo 2**(ADDR_WIDTH+1). Equals DEPTH exactly when the wrap bits differ and the lower bits are equal.
- Almost empty: o_almost_empty = (o_fill_level <= AE_THRESH). Combinational; asserted whenever o_Empty_Flag=1.
- Accept: rd_accept = i_rd_en & ~o_Empty_Flag.
  - o_mem_rd_en = rd_accept (combinational).
  - o_mem_rd_addr = rd pointer low bits.
  - On an accepted read, the rd pointer increments by 1 at the edge.
- Wrap: the pointer wraps naturally modulo 2**(ADDR_WIDTH+1); the low bits wrap DEPTH-1 -> 0 and toggle the MSB. No special-case logic is required.
- Latency: the memory is synchronous read, one cycle. o_rd_valid is registered rd_accept, high exactly the cycle after the accept. Back-to-back accepts give continuous o_rd_valid.
- Underflow: i_rd_en=1 while o_Empty_Flag=1 means the read is ignored and the pointer does not move. o_underflow=1 on the next cycle for one cycle.
- Simultaneous write and read when empty: the write becomes visible only through the updated i_wr_address. The read in that same cycle is rejected (no bypass) and counts as an underflow.
- Simultaneous write and read when non-empty: the read is accepted; the fill level is unchanged in the next cycle.
- Read at fill=1: accepted; o_Empty_Flag=1 the following cycle unless a write landed in the same cycle.
- Pointer error: if the computed fill level > DEPTH, set o_ptr_err. It stays set until i_rst. Reads still obey o_Empty_Flag.
- Reset mid-stream: pending o_rd_valid is cleared at that edge. Data in flight is discarded.
- No state machine beyond the pointer and two one-bit pipeline registers. All registered outputs change only on i_clk.

Decomposition:
- Shared package fifo_pkg holds:
  - default ADDR_WIDTH
  - DEPTH = 2**ADDR_WIDTH
  - PTR_WIDTH = ADDR_WIDTH+1
  - a pointer-difference (fill) function
  The write side uses the same package.
- Sub-module Empty_Flag_Gen: combinational pointer compare producing the empty flag. It is the mirror of the write side's full-flag generator and is instantiated here.
- Pointer register, valid/underflow registers and the status math stay in fifo_rd_ctrl.

Test Plan:
- Settings: ADDR_WIDTH=5, AE_THRESH=2.
- Reset: i_rst=1 for 2 cycles, i_wr_address=0 -> o_Empty_Flag=1, o_fill_level=0, o_almost_empty=1, o_rd_valid=0, o_rd_address=0, o_ptr_err=0.
- Basic read: i_wr_address=3, i_rd_en=1 for 3 cycles -> o_mem_rd_addr 0,1,2; o_rd_valid high for cycles 2-4; o_fill_level 3,2,1,0; then o_Empty_Flag=1; o_almost_empty=1 from fill=2 onward.
- Underflow: FIFO empty, i_rd_en=1 for 1 cycle -> o_mem_rd_en=0, pointer unchanged, o_underflow=1 next cycle only, o_rd_valid=0.
- Wrap and full level: rd pointer=31 (6'b011111), i_wr_address=6'b111111 -> o_fill_level=32. One read -> pointer 6'b100000, o_mem_rd_addr 31 then 0, fill=31.
- Simultaneous events: empty with i_wr_address stepping 4 -> 5 in the same cycle as i_rd_en=1 -> read rejected, o_underflow pulse. Next cycle i_rd_en=1 is accepted. Separately, at fill=10 with concurrent write and read, fill stays 10.
- Corruption and reset: force i_wr_address such that fill=40 -> o_ptr_err=1 and stays set. Assert i_rst mid-burst while o_rd_valid=1 -> next cycle o_rd_valid=0, pointer=0, o_ptr_err=0.
